// File: rtl/raizing_colmix_pkg.sv
// Shared defaults and width constants for the Raizing colour mixer.
package raizing_colmix_pkg;
  localparam int unsigned DEF_NLAYERS  = 4;
  localparam int unsigned DEF_PRIO_W   = 4;
  localparam int unsigned DEF_COL_W    = 11;
  localparam int unsigned DEF_BACKDROP = 0;
  localparam int unsigned PIX_W        = DEF_PRIO_W + DEF_COL_W;
  localparam int unsigned MASK_W       = DEF_NLAYERS + 1;

  // Index width for n layers, never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/raizing_prio_sel.sv
// Combinational arg-max over per-layer priorities; equal priority goes to the higher index.
module raizing_prio_sel
  import raizing_colmix_pkg::*;
#(
  parameter int unsigned NLAYERS = DEF_NLAYERS,
  parameter int unsigned PRIO_W  = DEF_PRIO_W,
  localparam int unsigned IDX_W  = idx_width(NLAYERS)
) (
  input  logic [NLAYERS*PRIO_W-1:0] prio,
  input  logic [NLAYERS-1:0]        opaque,
  output logic [IDX_W-1:0]          idx,
  output logic                      found
);

  logic [PRIO_W-1:0] best;

  // Scanning upward with >= lets a later (higher) layer take ties.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    best  = '0;
    for (int i = 0; i < NLAYERS; i++) begin
      if (opaque[i] && (!found || prio[i*PRIO_W +: PRIO_W] >= best)) begin
        idx   = IDX_W'(i);
        found = 1'b1;
        best  = prio[i*PRIO_W +: PRIO_W];
      end
    end
  end

endmodule

// File: rtl/raizing_colmix_n.sv
// Two-stage prioritised layer mixer with a frame-synchronised layer-enable mask.
module raizing_colmix_n
  import raizing_colmix_pkg::*;
#(
  parameter int unsigned NLAYERS  = DEF_NLAYERS,
  parameter int unsigned PRIO_W   = DEF_PRIO_W,
  parameter int unsigned COL_W    = DEF_COL_W,
  parameter int unsigned BACKDROP = DEF_BACKDROP
) (
  input  logic                              CLK96,
  input  logic                              RESET96,
  input  logic                              PIXEL_CEN,
  input  logic                              ACTIVE,
  input  logic [NLAYERS*(PRIO_W+COL_W)-1:0] LAYER_PIXELS,
  input  logic [COL_W-1:0]                  TEXT_PIXEL,
  input  logic                              EN_WE,
  input  logic [NLAYERS:0]                  EN_D,
  input  logic                              FRAME_START,
  output logic [COL_W-1:0]                  FINAL_PIXEL,
  output logic                              FINAL_VALID,
  output logic                              EN_PENDING
);

  localparam int unsigned SLICE_W = PRIO_W + COL_W;
  localparam int unsigned IDX_W   = idx_width(NLAYERS);
  localparam logic [COL_W-1:0] BD = COL_W'(BACKDROP);

  logic [NLAYERS:0]          mask;
  logic [NLAYERS:0]          pend_mask;

  logic [NLAYERS*PRIO_W-1:0] lay_prio;
  logic [NLAYERS*COL_W-1:0]  lay_col;
  logic [NLAYERS-1:0]        lay_opq;
  logic                      text_opq;
  logic [IDX_W-1:0]          win_idx;
  logic                      win_found;

  logic [NLAYERS-1:0]        s1_opaque;
  logic [NLAYERS*COL_W-1:0]  s1_cols;
  logic [IDX_W-1:0]          s1_idx;
  logic [COL_W-1:0]          s1_text;
  logic                      s1_text_opq;
  logic                      s1_active;

  // Split the packed {prio, colour} slices and qualify opacity with the live mask.
  always_comb begin
    lay_prio = '0;
    lay_col  = '0;
    lay_opq  = '0;
    for (int i = 0; i < NLAYERS; i++) begin
      lay_prio[i*PRIO_W +: PRIO_W] = LAYER_PIXELS[i*SLICE_W+COL_W +: PRIO_W];
      lay_col[i*COL_W +: COL_W]    = LAYER_PIXELS[i*SLICE_W +: COL_W];
      lay_opq[i] = (|LAYER_PIXELS[i*SLICE_W +: COL_W]) & mask[i];
    end
    text_opq = (|TEXT_PIXEL) & mask[NLAYERS];
  end

  raizing_prio_sel #(
    .NLAYERS (NLAYERS),
    .PRIO_W  (PRIO_W)
  ) u_prio_sel (
    .prio   (lay_prio),
    .opaque (lay_opq),
    .idx    (win_idx),
    .found  (win_found)
  );

  // Layer-enable mask: writes park in pend_mask until the next frame start.
  always_ff @(posedge CLK96) begin
    if (RESET96) begin
      mask       <= '1;
      pend_mask  <= '1;
      EN_PENDING <= 1'b0;
    end else if (EN_WE && FRAME_START) begin
      mask       <= EN_D;
      EN_PENDING <= 1'b0;
    end else if (EN_WE) begin
      pend_mask  <= EN_D;
      EN_PENDING <= 1'b1;
    end else if (FRAME_START && EN_PENDING) begin
      mask       <= pend_mask;
      EN_PENDING <= 1'b0;
    end
  end

  // Pixel pipeline, advanced only on the pixel clock enable.
  always_ff @(posedge CLK96) begin
    if (RESET96) begin
      s1_opaque   <= '0;
      s1_cols     <= '0;
      s1_idx      <= '0;
      s1_text     <= '0;
      s1_text_opq <= 1'b0;
      s1_active   <= 1'b0;
      FINAL_PIXEL <= BD;
      FINAL_VALID <= 1'b0;
    end else if (PIXEL_CEN) begin
      s1_opaque   <= lay_opq;
      s1_cols     <= lay_col;
      s1_idx      <= win_found ? win_idx : '0;
      s1_text     <= TEXT_PIXEL;
      s1_text_opq <= text_opq;
      s1_active   <= ACTIVE;
      FINAL_VALID <= s1_active;
      if (!s1_active)
        FINAL_PIXEL <= BD;
      else if (s1_text_opq)
        FINAL_PIXEL <= s1_text;
      else if (|s1_opaque)
        FINAL_PIXEL <= s1_cols[s1_idx*COL_W +: COL_W];
      else
        FINAL_PIXEL <= BD;
    end
  end

endmodule

// File: doc/raizing_colmix_n.md
RAIZING_COLMIX_N -- requirements
Module: raizing_colmix_n

Interface
REQ-001 The module SHALL have parameter NLAYERS, default 4, giving the number of prioritised layers (scroll layers plus object layer, with the highest index being the object layer).
REQ-002 The module SHALL have parameter PRIO_W, default 4, giving the width of the per-layer priority field.
REQ-003 The module SHALL have parameter COL_W, default 11, giving the width of the palette index.
REQ-004 The module SHALL have parameter BACKDROP, default 0, giving the COL_W value output when no layer is opaque.
REQ-005 Port CLK96: input, 1 bit; the single clock; all logic SHALL be clocked on its rising edge.
REQ-006 Port RESET96: input, 1 bit; reset is synchronous and active-high.
REQ-007 Port PIXEL_CEN: input, 1 bit; pixel clock enable; the pipeline SHALL advance only when it is high.
REQ-008 Port ACTIVE: input, 1 bit; display-active qualifier, sampled with the pixels.
REQ-009 Port LAYER_PIXELS: input, NLAYERS*(PRIO_W+COL_W) bits; layer i occupies slice i, laid out {prio, colour}.
REQ-010 Port TEXT_PIXEL: input, COL_W bits; unprioritised top layer.
REQ-011 Port EN_WE: input, 1 bit; single-cycle write strobe for the layer-enable mask.
REQ-012 Port EN_D: input, NLAYERS+1 bits; mask data; bit NLAYERS enables text, bit i enables layer i.
REQ-013 Port FRAME_START: input, 1 bit; single-cycle pulse at which a pending mask commits.
REQ-014 Port FINAL_PIXEL: output, COL_W bits; registered mixed palette index.
REQ-015 Port FINAL_VALID: output, 1 bit; registered; equals ACTIVE delayed through the pipeline.
REQ-016 Port EN_PENDING: output, 1 bit; high while a written mask awaits commit.

Function
REQ-017 A layer SHALL be opaque when its colour field is non-zero and its bit is set in the active mask.
REQ-018 Among opaque layers, the layer with the numerically greatest prio SHALL win; on equal prio, the higher layer index SHALL win.
REQ-019 An opaque text pixel (non-zero and enabled) SHALL override every prioritised layer.
REQ-020 With no opaque source, the output SHALL be BACKDROP; while the delayed ACTIVE is low, FINAL_PIXEL SHALL be BACKDROP.
REQ-021 The pipeline SHALL have two stages: stage 1 registers the opacity vector, the text result and the winner index/prio; stage 2 registers FINAL_PIXEL/FINAL_VALID. Latency is exactly 2 PIXEL_CEN pulses.
REQ-022 When PIXEL_CEN is low, all pipeline registers SHALL hold their values.
REQ-023 EN_WE SHALL load EN_D into a pending register and set EN_PENDING; a later EN_WE before commit SHALL overwrite the pending value.
REQ-024 FRAME_START with EN_PENDING set SHALL copy pending to the active mask and clear EN_PENDING in the same cycle; with EN_PENDING clear it SHALL do nothing.
REQ-025 If EN_WE and FRAME_START coincide, EN_D SHALL commit directly to the active mask and EN_PENDING SHALL end low.
REQ-026 The active mask SHALL be applied at stage 1; a commit SHALL never alter a pixel already in stage 2.

Reset
REQ-027 On RESET96, FINAL_PIXEL SHALL be BACKDROP, FINAL_VALID 0, EN_PENDING 0, the active mask all ones, and every stage-1 register zero.
REQ-028 Reset asserted mid-line SHALL discard in-flight pixels; the first valid output SHALL appear on the 2nd PIXEL_CEN after deassertion with ACTIVE high.

Structure
REQ-029 Default widths, the slice-width constant PIX_W = PRIO_W+COL_W and the mask-width constant SHALL live in the shared package raizing_colmix_pkg.
REQ-030 The arg-max with tie-break SHALL be the combinational sub-module raizing_prio_sel, parametrised by NLAYERS and PRIO_W, returning the winner index and a found flag.

Verification
REQ-031 Test: L0=(p3,0x010), L1=(p3,0x020), L2=(p1,0x030), L3=(p0,0x000), text 0, ACTIVE 1 -> 0x020 after 2 CEN.
REQ-032 Test: same stimulus with TEXT_PIXEL=0x7FF -> 0x7FF; with mask bit 4 cleared and committed -> 0x020.
REQ-033 Test: EN_WE with EN_D=5'b11101, no FRAME_START -> EN_PENDING=1 and output unchanged; FRAME_START -> L1 is masked and output becomes 0x010.
REQ-034 Test: EN_WE and FRAME_START in the same cycle with EN_D=5'b10111 -> mask applied at once, EN_PENDING stays 0.
REQ-035 Test: PIXEL_CEN every 4th cycle with a stall of 10 cycles -> FINAL_PIXEL holds; all layers transparent -> BACKDROP; ACTIVE 0 -> FINAL_VALID 0 two CEN later.
REQ-036 Test: RESET96 pulsed mid-line -> outputs BACKDROP/0 on the next edge, mask all ones, first valid output on the 2nd CEN after release.
